// File: rtl/paddle_input_pkg.sv
// paddle_input_pkg: shared constants and types for the paddle input front-end.
//   KEY_* : bit positions of each push-button inside the 4-bit KEY bus
//   dir_t : paddle move direction
//   move_state_t : states of the hold-to-repeat move sequencer
package paddle_input_pkg;

  localparam int unsigned KEY_LEFT   = 3;
  localparam int unsigned KEY_RIGHT  = 2;
  localparam int unsigned KEY_PAUSE  = 1;
  localparam int unsigned KEY_LAUNCH = 0;
  localparam int unsigned NUM_KEYS   = 4;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_DELAY  = 2'd1,
    M_REPEAT = 2'd2
  } move_state_t;

  // Counter width shared by every timer: one bit of headroom over the largest limit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// paddle_input_ctrl_if: valid/ready channel carrying paddle move requests.
//   move_valid : a move request is pending (producer)
//   move_dir   : 0 = left, 1 = right, stable while move_valid (producer)
//   move_ready : consumer accepts the pending move (consumer)
interface paddle_input_ctrl_if;

  logic move_valid;
  logic move_dir;
  logic move_ready;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);

endinterface

// File: rtl/paddle_input_ctrl_key_debounce.sv
// key_debounce: 2-FF synchronizer plus counter debouncer for one active-low button.
//   clk, reset : clock and synchronous active-low reset
//   key_n      : raw button, 0 = pressed
//   level      : debounced level, 1 = pressed
//   press      : one-cycle pulse in the cycle level rises 0->1
module key_debounce
  #(parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20)
  (input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then flip the level only after CNT_MAX consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= ~level;
        press <= ~level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: converts the four DE1 push-buttons into Breakout game commands.
//   clk, reset : clock and synchronous active-low reset
//   KEY        : raw buttons, active-low ([3] left, [2] right, [1] pause, [0] launch)
//   move_bus   : valid/ready move request channel (producer side)
//   launch     : one-cycle pulse per launch press while not paused
//   paused     : pause level, toggled by each pause press
module paddle_input_ctrl
  import paddle_input_pkg::*;
  #(parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 2500000)
  (input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_KEYS-1:0]  KEY,
   paddle_input_ctrl_if.master  move_bus,
   output logic                 launch,
   output logic                 paused);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] lvl;
  logic [NUM_KEYS-1:0] prs;
  logic                unused_lvl;

  // One debouncer per button.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key (
      .clk   (clk),
      .reset (reset),
      .key_n (KEY[g]),
      .level (lvl[g]),
      .press (prs[g])
    );
  end

  // Pause and launch act on press pulses only.
  assign unused_lvl = lvl[KEY_PAUSE] ^ lvl[KEY_LAUNCH];

  move_state_t      state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  dir_t             dir_q, dir_d;
  logic             issue_c;
  logic             valid_q, valid_d;
  dir_t             mdir_q, mdir_d;
  logic             launch_d;
  logic             paused_d;

  logic active_held_c;
  logic other_held_c;
  logic other_press_c;
  dir_t other_dir_c;

  assign active_held_c = (dir_q == DIR_LEFT) ? lvl[KEY_LEFT]  : lvl[KEY_RIGHT];
  assign other_held_c  = (dir_q == DIR_LEFT) ? lvl[KEY_RIGHT] : lvl[KEY_LEFT];
  assign other_press_c = (dir_q == DIR_LEFT) ? prs[KEY_RIGHT] : prs[KEY_LEFT];
  assign other_dir_c   = dir_t'(~dir_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= M_IDLE;
      tmr_q   <= '0;
      dir_q   <= DIR_LEFT;
      valid_q <= 1'b0;
      mdir_q  <= DIR_LEFT;
      launch  <= 1'b0;
      paused  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      mdir_q  <= mdir_d;
      launch  <= launch_d;
      paused  <= paused_d;
    end
  end

  // Next-state: hold-to-repeat sequencing and move issue decisions.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dir_d   = dir_q;
    issue_c = 1'b0;
    if (paused) begin
      state_d = M_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        M_IDLE: begin
          // Left wins when both directions are pressed in the same cycle.
          if (prs[KEY_LEFT]) begin
            dir_d   = DIR_LEFT;
            issue_c = 1'b1;
            state_d = M_DELAY;
            tmr_d   = '0;
          end else if (prs[KEY_RIGHT]) begin
            dir_d   = DIR_RIGHT;
            issue_c = 1'b1;
            state_d = M_DELAY;
            tmr_d   = '0;
          end
        end
        M_DELAY, M_REPEAT: begin
          if (other_press_c || (!active_held_c && other_held_c)) begin
            dir_d   = other_dir_c;
            issue_c = 1'b1;
            state_d = M_DELAY;
            tmr_d   = '0;
          end else if (!active_held_c) begin
            state_d = M_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == ((state_q == M_DELAY) ? DELAY_LAST : RATE_LAST)) begin
            issue_c = 1'b1;
            state_d = M_REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = M_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Outputs: single-slot move handshake, launch pulse, pause toggle.
  always_comb begin
    valid_d  = valid_q;
    mdir_d   = mdir_q;
    launch_d = 1'b0;
    paused_d = paused;
    // A new move is taken only when the slot is empty or being emptied this cycle.
    if (issue_c && (!valid_q || move_bus.move_ready)) begin
      valid_d = 1'b1;
      mdir_d  = dir_d;
    end else if (move_bus.move_ready) begin
      valid_d = 1'b0;
    end
    if (prs[KEY_PAUSE]) paused_d = ~paused;
    launch_d = prs[KEY_LAUNCH] && !paused;
  end

  assign move_bus.move_valid = valid_q;
  assign move_bus.move_dir   = mdir_q;

endmodule
